shift_cmd_queue: RTL and testbench

SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

---
 rtl/shifter_pkg.sv | 18 +
 rtl/BarrelShifter.sv | 20 ++
 rtl/shift_cmd_queue.sv | 97 +++++++++
 tb/tb_shift_cmd_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared shift-command types: direction encoding and the command record
// at the default 8-bit operand width.
package shifter_pkg;

    localparam int SHIFT_WIDTH = 8;

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_t;

    typedef struct packed {
        logic [SHIFT_WIDTH-1:0]         data;
        logic [$clog2(SHIFT_WIDTH)-1:0] amount;
        shift_dir_t                     dir;
    } shift_cmd_t;

endpackage

// File: rtl/BarrelShifter.sv
// Combinational logical shifter with zero fill; direction chooses left or right.
module BarrelShifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shift_amount,
    input  logic                     shift_direction,
    output logic [WIDTH-1:0]         data_out
);

    always_comb begin
        data_out = data_in >> shift_amount;
        if (shift_dir_t'(shift_direction) == SHIFT_LEFT) begin
            data_out = data_in << shift_amount;
        end
    end

endmodule

// File: rtl/shift_cmd_queue.sv
// Command FIFO feeding a barrel shifter, with one registered result stage.
// Holds up to DEPTH queued commands plus one result in the output register.
module shift_cmd_queue
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amount,
    input  logic                       in_dir,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int AW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Packages cannot take parameters, so the command record is re-declared
    // here at this instance's WIDTH; it shadows the package default.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    amount;
        shift_dir_t       dir;
    } shift_cmd_t;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and out_data is frozen while out_valid is
    // high and out_ready low.
    shift_cmd_t       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] shifted;
    logic             push;
    logic             pop;
    logic             out_free;
    shift_cmd_t       head;

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready && !rst;
    assign out_free = !out_valid_q || out_ready;
    assign pop      = out_free && (count_q != '0);
    assign head     = mem[rd_ptr];

    BarrelShifter #(.WIDTH(WIDTH)) u_shifter (
        .data_in        (head.data),
        .shift_amount   (head.amount),
        .shift_direction(head.dir),
        .data_out       (shifted)
    );

    // Storage is never cleared; reset only drops the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: in_data, amount: in_amount, dir: shift_dir_t'(in_dir)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                out_data_q  <= shifted;
                out_valid_q <= 1'b1;
            end else if (out_free) begin
                out_valid_q <= 1'b0;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign busy      = (count_q != '0) || out_valid_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench for shift_cmd_queue: directed scenarios plus a random
// push/pop run against a queue-based model and an expected-result scoreboard.
module tb_shift_cmd_queue;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(W);
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amount;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queued results in push order, plus the held output register.
    logic [W-1:0] m_fifo[$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [W-1:0] exp_q[$];

    shift_cmd_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amount(in_amount), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .busy(busy)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amount = '0;
        in_dir = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_data = '0;
    end

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d,
                                                input logic [AW-1:0] a,
                                                input logic dir);
        longint unsigned p;
        longint unsigned v;
        p = longint'(1) << a;
        if (dir) v = (longint'(d) * p) % (longint'(1) << W);
        else     v = longint'(d) / p;
        return W'(v);
    endfunction

    // driver: apply inputs, advance the model by one edge, sample #1 later
    task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] d,
                               input logic [AW-1:0] a, input logic dr,
                               input logic ordy);
        logic acc;
        logic free;
        rst = r; in_valid = v; in_data = d; in_amount = a; in_dir = dr;
        out_ready = ordy;
        if (r) begin
            m_fifo.delete();
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            acc  = v && (m_fifo.size() < DEPTH);
            free = !m_valid || ordy;
            if (free) begin
                if (m_fifo.size() > 0) begin
                    m_data  = m_fifo.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (acc) m_fifo.push_back(ref_shift(d, a, dr));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, ordy);
    endtask

    task automatic test_reset;
        drive_cycle(1'b1, 1'b1, 8'h3C, 3'd1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 8'h3C, 3'd1, 1'b1, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        idle(1'b1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_push_ignored got out_valid %b exp 0", out_valid); end
    endtask

    task automatic test_single;
        drive_cycle(1'b0, 1'b1, 8'b10101010, 3'd5, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL single_after_push got v=%b cnt=%0d exp v=0 cnt=1", out_valid, count); end
        idle(1'b1);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'b00000101) begin n_fail++; $display("FAIL single_result got v=%b d=%b exp v=1 d=00000101", out_valid, out_data); end
        n_tests++; if (count !== 3'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got cnt=%0d busy=%b exp cnt=0 busy=1", count, busy); end
        idle(1'b1);
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drained got v=%b busy=%b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_back_to_back;
        drive_cycle(1'b0, 1'b1, 8'b00000101, 3'd2, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1, 8'hFF, 3'd0, 1'b1, 1'b1);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'b00010100) begin n_fail++; $display("FAIL b2b_first got v=%b d=%h exp v=1 d=14", out_valid, out_data); end
        idle(1'b1);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second got v=%b d=%h exp v=1 d=ff", out_valid, out_data); end
        idle(1'b1);
        n_tests++; if (out_valid !== 1'b0 || out_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_hold got v=%b d=%h exp v=0 d=ff", out_valid, out_data); end
    endtask

    task automatic test_full;
        logic [W-1:0]  d [6];
        logic [AW-1:0] a [6];
        logic          r [6];
        for (int i = 0; i < 6; i++) begin
            d[i] = W'($urandom);
            a[i] = AW'($urandom_range(0, W-1));
            r[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (in_ready !== (i < 5)) begin n_fail++; $display("FAIL full_in_ready[%0d] got %b exp %b", i, in_ready, (i < 5)); end
            drive_cycle(1'b0, 1'b1, d[i], a[i], r[i], 1'b0);
        end
        n_tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_count got cnt=%0d rdy=%b exp 4 0", count, in_ready); end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== ref_shift(d[i], a[i], r[i])) begin
                n_fail++; $display("FAIL full_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, ref_shift(d[i], a[i], r[i]));
            end
            idle(1'b1);
        end
        n_tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL full_empty got v=%b cnt=%0d exp 0 0", out_valid, count); end
    endtask

    task automatic test_pulse;
        logic [W-1:0] d [5];
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            d[i] = W'($urandom);
            drive_cycle(1'b0, 1'b1, d[i], 3'd0, 1'b0, 1'b0);
        end
        drive_cycle(1'b0, 1'b1, 8'h81, 3'd1, 1'b1, 1'b1);
        n_tests++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL pulse_pop got cnt=%0d rdy=%b exp 3 1", count, in_ready); end
        n_tests++; if (out_data !== d[1]) begin n_fail++; $display("FAIL pulse_next got %h exp %h", out_data, d[1]); end
        drive_cycle(1'b0, 1'b1, 8'h81, 3'd1, 1'b1, 1'b0);
        n_tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL pulse_refill got cnt=%0d rdy=%b exp 4 0", count, in_ready); end
        for (int i = 1; i < 6; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== ((i < 5) ? d[i] : 8'h02)) begin
                n_fail++; $display("FAIL pulse_order[%0d] got v=%b d=%h exp %h", i, out_valid, out_data, (i < 5) ? d[i] : 8'h02);
            end
            idle(1'b1);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, W'($urandom), 3'd1, 1'b1, 1'b0);
        n_tests++; if (count !== 3'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup got cnt=%0d v=%b exp 3 1", count, out_valid); end
        drive_cycle(1'b1, 1'b1, 8'h55, 3'd0, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_state got v=%b cnt=%0d rdy=%b busy=%b exp 0 0 1 0", out_valid, count, in_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale[%0d] got v=%b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_random;
        logic          v;
        logic          ordy;
        logic [W-1:0]  d;
        logic [AW-1:0] a;
        logic          r;
        logic [W-1:0]  e;
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            v    = ($urandom_range(0, 99) < 60);
            ordy = (c >= 560) || ($urandom_range(0, 99) < 50);
            if (c >= 560) v = 1'b0;
            d = W'($urandom); a = AW'($urandom_range(0, W-1)); r = 1'($urandom_range(0, 1));
            if (out_valid && ordy) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra result %h with empty scoreboard", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL rand_order cycle %0d got %h exp %h", c, out_data, e); end
                end
            end
            if (v && in_ready) exp_q.push_back(ref_shift(d, a, r));
            drive_cycle(1'b0, v, d, a, r, ordy);
            n_tests++;
            if (count !== CW'(m_fifo.size()) || out_valid !== m_valid || out_data !== m_data ||
                in_ready !== (m_fifo.size() < DEPTH) || count > CW'(DEPTH)) begin
                n_fail++; $display("FAIL rand_state cycle %0d got cnt=%0d v=%b d=%h rdy=%b exp cnt=%0d v=%b d=%h",
                                   c, count, out_valid, out_data, in_ready, m_fifo.size(), m_valid, m_data);
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover got %0d pending exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_pulse();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
